// File: rtl/aes_pkg.sv
// Shared AES-128 tables: forward S-box, round constants and the 128-bit key type.
package aes_pkg;

    typedef logic [127:0] aes_key_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Index = round number; entries outside 1..10 are never used for a real round.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/aes_key_expansion_key_single_round.sv
// One AES-128 key-schedule step with registered output; holds its result until re-enabled.
module key_single_round
    import aes_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clk_en_i,
    input  logic [7:0]   rcon,
    input  logic [31:0]  iv,
    input  logic [127:0] key_i,
    output logic [127:0] key_o,
    output logic         key_valid_o
);

    aes_key_t    key_d, key_q;
    logic        valid_d, valid_q;
    logic [31:0] w4, w5, w6, w7;

    always_comb begin
        w4 = key_i[127:96] ^ sub_word({iv[23:0], iv[31:24]}) ^ {rcon, 24'h0};
        w5 = key_i[95:64] ^ w4;
        w6 = key_i[63:32] ^ w5;
        w7 = key_i[31:0]  ^ w6;
        key_d   = key_q;
        valid_d = valid_q;
        if (clk_en_i) begin
            key_d   = {w4, w5, w6, w7};
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            key_q   <= key_d;
            valid_q <= valid_d;
        end
    end

    assign key_o       = key_q;
    assign key_valid_o = valid_q;

endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key expansion reusing one key_single_round across all ten rounds.
// Define AES_KEY_EXP_ASSERT_EN to compile in the done-ordering / key-stability assertions.
module aes_key_expansion
    import aes_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         begin_key_gen_i,
    input  logic [127:0] initial_key,
    output logic [127:0] round_keys      [0:10],
    output logic         round_keys_done [0:10]
);

    localparam logic [3:0] RND_FIRST = 4'd1;
    localparam logic [3:0] RND_LAST  = 4'd10;
    localparam logic [3:0] RND_IDLE  = 4'd11;

    logic [3:0]  rnd_d, rnd_q;
    aes_key_t    key0_d, key0_q;
    aes_key_t    arch_d [1:10];
    aes_key_t    arch_q [1:10];
    logic [10:0] done_d, done_q;

    logic        step_en;
    aes_key_t    step_key;
    aes_key_t    new_key;
    logic        new_valid;

    // Round r chains from the round r-1 result still sitting in the step register.
    assign step_en  = !begin_key_gen_i && (rnd_q >= RND_FIRST) && (rnd_q <= RND_LAST);
    assign step_key = (rnd_q == RND_FIRST) ? key0_q : new_key;

    key_single_round u_round (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clk_en_i    (step_en),
        .rcon        (RCON[rnd_q]),
        .iv          (step_key[31:0]),
        .key_i       (step_key),
        .key_o       (new_key),
        .key_valid_o (new_valid)
    );

    always_comb begin
        rnd_d  = rnd_q;
        key0_d = key0_q;
        arch_d = arch_q;
        done_d = done_q;
        // The newest key lives in the step register; archive it one edge later.
        for (int unsigned i = 1; i <= 10; i++) begin
            if (32'(rnd_q) == i + 1) begin
                arch_d[i] = new_key;
            end
        end
        if (begin_key_gen_i) begin
            key0_d = initial_key;
            done_d = 11'b000_0000_0001;
            rnd_d  = RND_FIRST;
        end else if (step_en) begin
            done_d[rnd_q] = 1'b1;
            rnd_d         = rnd_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rnd_q  <= RND_IDLE;
            key0_q <= '0;
            done_q <= '0;
            for (int unsigned i = 1; i <= 10; i++) begin
                arch_q[i] <= '0;
            end
        end else begin
            rnd_q  <= rnd_d;
            key0_q <= key0_d;
            done_q <= done_d;
            arch_q <= arch_d;
        end
    end

    always_comb begin
        round_keys[0]      = key0_q;
        round_keys_done[0] = done_q[0];
        for (int unsigned i = 1; i <= 10; i++) begin
            round_keys[i]      = (new_valid && 32'(rnd_q) == i + 1) ? new_key : arch_q[i];
            round_keys_done[i] = done_q[i];
        end
    end

`ifdef AES_KEY_EXP_ASSERT_EN
    for (genvar i = 0; i <= 10; i++) begin : g_chk
        a_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (done_q[i] && !begin_key_gen_i) |=> $stable(round_keys[i]));
        if (i > 0) begin : g_order
            a_implies: assert property (@(posedge clk_i) disable iff (!rst_ni)
                done_q[i] |-> done_q[i-1]);
            a_rise: assert property (@(posedge clk_i) disable iff (!rst_ni)
                $rose(done_q[i]) |-> $past(done_q[i-1]));
        end
    end
`else
`endif

endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed self-checking bench for aes_key_expansion plus a standalone key_single_round.
module tb_aes_key_expansion;

    logic         clk;
    logic         rst_n;
    logic         begin_kg;
    logic [127:0] initial_key;
    logic [127:0] round_keys      [0:10];
    logic         round_keys_done [0:10];

    logic         sr_en;
    logic [127:0] sr_key_i;
    logic [127:0] sr_key_o;
    logic         sr_valid;

    int errors = 0;
    int checks = 0;

    logic [127:0] exp_a [1:10];
    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes_key_expansion dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .begin_key_gen_i (begin_kg),
        .initial_key     (initial_key),
        .round_keys      (round_keys),
        .round_keys_done (round_keys_done)
    );

    key_single_round u_sr (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clk_en_i    (sr_en),
        .rcon        (8'h01),
        .iv          (sr_key_i[31:0]),
        .key_i       (sr_key_i),
        .key_o       (sr_key_o),
        .key_valid_o (sr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic all_zero();
        logic z = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            if (round_keys[i] !== '0 || round_keys_done[i] !== 1'b0) z = 1'b0;
        end
        return z;
    endfunction

    function automatic logic done_range(input int lo, input int hi, input logic v);
        logic ok = 1'b1;
        for (int i = lo; i <= hi; i++) begin
            if (round_keys_done[i] !== v) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic start_key(input logic [127:0] k);
        @(negedge clk);
        begin_kg    = 1'b1;
        initial_key = k;
        @(posedge clk); #1;
        @(negedge clk);
        begin_kg = 1'b0;
    endtask

    initial begin
        exp_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst_n       = 1'b0;
        begin_kg    = 1'b1;
        initial_key = KEY_A;
        sr_en       = 1'b0;
        sr_key_i    = KEY_A;

        #23;
        chk1("reset_all_zero", all_zero(), 1'b1);
        chk1("reset_sr_valid", sr_valid, 1'b0);

        // Begin high through reset release; one start edge, then drop begin.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk128("start_rk0", round_keys[0], KEY_A);
        chk1("start_done0", round_keys_done[0], 1'b1);
        chk1("start_done1", round_keys_done[1], 1'b0);
        @(negedge clk);
        begin_kg    = 1'b0;
        initial_key = 128'hffeeddccbbaa99887766554433221100;

        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            chk1($sformatf("lat_done%0d", i), round_keys_done[i], 1'b1);
            if (i < 10) chk1($sformatf("lat_next%0d", i), round_keys_done[i+1], 1'b0);
            chk128($sformatf("vecA_rk%0d", i), round_keys[i], exp_a[i]);
        end
        chk128("vecA_rk0_held", round_keys[0], KEY_A);

        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk1("idle_all_done", done_range(0, 10, 1'b1), 1'b1);
        end
        chk128("idle_rk1", round_keys[1], exp_a[1]);
        chk128("idle_rk10", round_keys[10], exp_a[10]);

        // Holding begin high reloads without advancing.
        @(negedge clk);
        begin_kg    = 1'b1;
        initial_key = '0;
        repeat (3) @(posedge clk);
        #1;
        chk1("hold_done0", round_keys_done[0], 1'b1);
        chk1("hold_no_adv", done_range(1, 10, 1'b0), 1'b1);
        @(negedge clk);
        begin_kg = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk128("zero_rk1", round_keys[1], 128'h62636363626363636263636362636363);
        chk128("zero_rk10", round_keys[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Restart with KEY_A after five rounds of an all-zero expansion.
        start_key('0);
        repeat (5) @(posedge clk);
        #1;
        chk1("mid_done5", round_keys_done[5], 1'b1);
        chk1("mid_done6", round_keys_done[6], 1'b0);
        @(negedge clk);
        begin_kg    = 1'b1;
        initial_key = KEY_A;
        @(posedge clk); #1;
        chk1("restart_cleared", done_range(1, 10, 1'b0), 1'b1);
        @(negedge clk);
        begin_kg = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk128("restart_rk1", round_keys[1], exp_a[1]);
        chk128("restart_rk2", round_keys[2], exp_a[2]);
        chk128("restart_rk10", round_keys[10], exp_a[10]);
        chk1("restart_all_done", done_range(0, 10, 1'b1), 1'b1);

        // Asynchronous reset pulse during round 4.
        start_key(KEY_A);
        repeat (4) @(posedge clk);
        #1;
        chk1("pre_rst_done4", round_keys_done[4], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("async_rst_zero", all_zero(), 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk1("post_rst_idle", all_zero(), 1'b1);

        // Standalone single round.
        @(negedge clk);
        sr_key_i = KEY_A;
        sr_en    = 1'b1;
        @(posedge clk); #1;
        chk128("sr_key_o", sr_key_o, exp_a[1]);
        chk1("sr_valid", sr_valid, 1'b1);
        @(negedge clk);
        sr_en    = 1'b0;
        sr_key_i = '0;
        @(posedge clk); #1;
        chk128("sr_hold", sr_key_o, exp_a[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_key_expansion.md
AES_KEY_EXPANSION -- requirements
Module: aes_key_expansion

Interface
REQ-001 The module SHALL have no parameters and SHALL support AES-128 only (11 round keys, 10 expansion rounds).
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_ni  input  1  asynchronous, active-low reset.
REQ-004 begin_key_gen_i  input  1  synchronous start/reload request, level-sampled.
REQ-005 initial_key  input  128  cipher key, bit 127 = first key byte (FIPS-197 byte order).
REQ-006 round_keys  output  128 x [0:10]  unpacked array of round keys; index 0 = cipher key.
REQ-007 round_keys_done  output  1 x [0:10]  unpacked array; bit i high = round_keys[i] valid.

Function
REQ-008 Each rising edge with begin_key_gen_i=1 SHALL load round_keys[0]<=initial_key, set done[0]=1, clear done[1..10] and set the round counter to 1.
REQ-009 While begin_key_gen_i stays high, the block SHALL reload on every edge and SHALL NOT advance.
REQ-010 Each edge with begin_key_gen_i=0 and counter r in 1..10 SHALL write round_keys[r] = expand(round_keys[r-1], rcon[r]), set done[r]=1 and increment r.
REQ-011 Latency: round_keys[i] and done[i] SHALL be valid i edges after the first edge with begin_key_gen_i low; round_keys[10] SHALL be valid 10 edges after that edge.
REQ-012 After round 10 the block SHALL idle (counter = 11), hold all keys, and keep all done bits high until the next start or reset.
REQ-013 Keys already marked done SHALL NOT change except by start or reset; a start mid-expansion SHALL abort and restart from round 1.
REQ-014 expand(): w4=w0^SubWord(RotWord(w3))^{rcon,24'h0}, w5=w1^w4, w6=w2^w5, w7=w3^w6, where w0 = bits 127:96.
REQ-015 RotWord SHALL be a one-byte left rotation; SubWord SHALL apply the FIPS-197 forward S-box to each byte.
REQ-016 rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36 (hex).
REQ-017 initial_key SHALL be sampled only on start edges; later changes SHALL NOT affect an expansion in progress.

Reset
REQ-018 While rst_ni=0, all round_keys SHALL be 0, all round_keys_done SHALL be 0 and the counter SHALL be idle (11), asynchronously.
REQ-019 Reset asserted mid-expansion SHALL discard all progress; after release, nothing SHALL happen until a start.

Configuration
REQ-020 With AES_KEY_EXP_ASSERT_EN defined, the block SHALL include concurrent assertions: done bits only rise in index order; done[i] implies done[i-1]; a done key stays stable until start or reset.
REQ-021 Without AES_KEY_EXP_ASSERT_EN, no assertion code SHALL be compiled, and function SHALL be identical.

Structure
REQ-022 A shared package aes_pkg SHALL hold the S-box table, the rcon table, and a 128-bit key typedef.
REQ-023 One sub-module key_single_round SHALL hold one expansion step. Ports: clk_i, rst_ni, clk_en_i, rcon[7:0], iv[31:0] (the word fed to RotWord/SubWord), key_i[128], key_o[128], key_valid_o.
REQ-024 key_single_round SHALL register key_o and key_valid_o one edge after an edge with clk_en_i=1, and SHALL hold both outputs otherwise.
REQ-025 aes_key_expansion SHALL reuse a single S-box datapath (4 byte lookups) across rounds, not 10 unrolled rounds.

Verification
REQ-026 Hold begin high through reset, release, drop begin after 1 edge, key 2b7e151628aed2a6abf7158809cf4f3c -> round_keys[1]=a0fafe1788542cb123a339392a6c7605, [2]=f2c295f27a96b9435935807a7359f67f, [10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-027 Same start -> done[i] rises exactly i edges after begin falls, then all 11 done bits stay high for 20 more cycles.
REQ-028 Key all-zero -> round_keys[1]=62636363626363636263636362636363, round_keys[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-029 Restart with a new key at round 5 -> done[1..10] clear on the start edge; the final keys match the new key's schedule.
REQ-030 Pulse rst_ni low at round 4 -> all outputs are 0 immediately, and stay 0 until the next start.
REQ-031 key_single_round standalone: rcon=01, iv=09cf4f3c, key_i=2b7e...4f3c, clk_en_i=1 -> key_o=a0fafe17...7605 and key_valid_o=1 one edge later.
